// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer,
// bubble-injecting flush and saturating stall/flush performance counters.
module pipe_stage_skid #(
  parameter int                 CTRL_W    = 16,
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [CTRL_W-1:0]  up_ctrl,
  input  logic [INSTR_W-1:0] up_instr,
  input  logic [PC_W-1:0]    up_pc,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [CTRL_W-1:0]  dn_ctrl,
  output logic [INSTR_W-1:0] dn_instr,
  output logic [PC_W-1:0]    dn_pc,
  input  logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e               state_q, state_d;
  logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d, skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]      main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic                 main_v, skid_v, up_fire, dn_fire;

  assign main_v   = (state_q != ST_EMPTY);
  assign skid_v   = (state_q == ST_SKID);
  // Ready comes only from registered state, never from dn_ready.
  assign up_ready = !skid_v && !rst;
  assign dn_valid = main_v && !flush && !rst;
  assign up_fire  = up_valid && up_ready;
  assign dn_fire  = dn_valid && dn_ready;

  assign dn_ctrl   = dn_valid ? main_ctrl_q  : {CTRL_W{1'b0}};
  assign dn_instr  = dn_valid ? main_instr_q : NOP_INSTR;
  assign dn_pc     = dn_valid ? main_pc_q    : {PC_W{1'b0}};
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Next-state, payload movement and counter update.
  always_comb begin
    state_d      = state_q;
    main_ctrl_d  = main_ctrl_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    case (state_q)
      ST_EMPTY: begin
        if (up_fire) begin
          state_d      = ST_FULL;
          main_ctrl_d  = up_ctrl;
          main_instr_d = up_instr;
          main_pc_d    = up_pc;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (up_fire && dn_fire) begin
          main_ctrl_d  = up_ctrl;
          main_instr_d = up_instr;
          main_pc_d    = up_pc;
        end else if (up_fire) begin
          state_d      = ST_SKID;
          skid_ctrl_d  = up_ctrl;
          skid_instr_d = up_instr;
          skid_pc_d    = up_pc;
        end else if (dn_fire) begin
          state_d      = ST_EMPTY;
          main_ctrl_d  = {CTRL_W{1'b0}};
          main_instr_d = NOP_INSTR;
          main_pc_d    = {PC_W{1'b0}};
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_SKID: begin
        if (dn_fire) begin
          state_d      = ST_FULL;
          main_ctrl_d  = skid_ctrl_q;
          main_instr_d = skid_instr_q;
          main_pc_d    = skid_pc_q;
          skid_ctrl_d  = {CTRL_W{1'b0}};
          skid_instr_d = NOP_INSTR;
          skid_pc_d    = {PC_W{1'b0}};
        end else begin
          state_d = ST_SKID;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush overrides any movement, including an accepted upstream word.
    if (flush) begin
      state_d      = ST_EMPTY;
      main_ctrl_d  = {CTRL_W{1'b0}};
      main_instr_d = NOP_INSTR;
      main_pc_d    = {PC_W{1'b0}};
      skid_ctrl_d  = {CTRL_W{1'b0}};
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = {PC_W{1'b0}};
    end else begin
      state_d = state_d;
    end

    if (dn_valid && !dn_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    if (flush && main_v && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State, payload and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      main_ctrl_q  <= {CTRL_W{1'b0}};
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= {PC_W{1'b0}};
      skid_ctrl_q  <= {CTRL_W{1'b0}};
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= {PC_W{1'b0}};
      stall_cnt_q  <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      main_ctrl_q  <= main_ctrl_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule
